row_sequencer: RTL and testbench
================================

ROW_SEQUENCER -- requirements
Module: row_sequencer

Interface
REQ-001 Parameter: NUM_ROWS, 10, number of weight rows (output classes) evaluated per image, 1..16.
REQ-002 Parameter: TIMEOUT_CYCLES, 2047, max cycles to wait for done_row per row, 1..65535.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  request to evaluate all rows; sampled only in IDLE.
REQ-006 done_row  input  1  multiplier row-complete strobe.
REQ-007 row_result  input  16  multiplier row sum, unsigned, valid while done_row=1.
REQ-008 overflow  input  1  multiplier overflow flag, valid while done_row=1.
REQ-009 begin_mult  output  1  one-cycle pulse starting the multiplier on row_select.
REQ-010 row_select  output  4  row index currently issued to the multiplier.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse when the evaluation finishes or aborts.
REQ-013 class_out  output  4  index of the winning row.
REQ-014 max_value  output  16  effective value of the winning row.
REQ-015 ovf_mask  output  16  bit i set when row i reported overflow; bits >= NUM_ROWS are 0.
REQ-016 timeout_err  output  1  set when a row did not complete within TIMEOUT_CYCLES.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, CAPTURE, FINISH; all outputs registered.
REQ-018 IDLE: start=1 -> ISSUE next cycle; row_select<=0, class_out<=0, max_value<=0, ovf_mask<=0, timeout_err<=0 on the same edge.
REQ-019 ISSUE lasts exactly one cycle with begin_mult=1, then -> WAIT; begin_mult=0 in all other states.
REQ-020 row_select stays stable from ISSUE through CAPTURE of that row.
REQ-021 WAIT: done_row=1 -> CAPTURE, with row_result and overflow latched on that edge; done_row is ignored in every other state.
REQ-022 WAIT: a 16-bit wait counter clears on entry and increments each cycle; when it reaches TIMEOUT_CYCLES with done_row=0 -> FINISH with timeout_err<=1; rows already captured keep their results.
REQ-023 CAPTURE: effective value = 16'hFFFF if the latched overflow=1, else the latched row_result; ovf_mask[row_select]<=latched overflow.
REQ-024 CAPTURE: row 0 always loads class_out/max_value; a later row loads them only if its effective value > max_value (strict), so ties keep the lower index.
REQ-025 CAPTURE: row_select = NUM_ROWS-1 -> FINISH; otherwise row_select increments and -> ISSUE.
REQ-026 FINISH lasts one cycle with done=1, then -> IDLE.
REQ-027 class_out, max_value, ovf_mask and timeout_err hold their values in IDLE until the next accepted start.
REQ-028 start while busy=1 is ignored and has no side effects.
REQ-029 Latency, no timeout: start sampled at edge T -> begin_mult for row 0 during cycle T+1; for each row, done_row sampled at edge W -> next begin_mult during cycle W+2; done during cycle W+2 after the last row.
REQ-030 done_row and start both high in the same IDLE cycle: start is accepted and done_row is ignored.

Reset
REQ-031 While rst=1, independent of clk: state=IDLE; begin_mult, busy, done, timeout_err = 0; row_select, class_out = 0; max_value, ovf_mask = 0; wait counter = 0.
REQ-032 rst asserted mid-evaluation aborts immediately with no done pulse; the first start after rst deasserts begins a fresh evaluation at row 0.

Verification
REQ-033 Model returns row_result = 100*(row+1), no overflow, 5 cycles after each begin_mult -> ten begin_mult pulses with row_select 0..9, class_out=9, max_value=1000, ovf_mask=0, one done pulse.
REQ-034 All rows return 784 -> class_out=0 (tie rule), max_value=784.
REQ-035 Row 3 reports overflow=1, others return 500 -> class_out=3, max_value=16'hFFFF, ovf_mask=16'h0008.
REQ-036 Model never answers row 2, TIMEOUT_CYCLES=50 -> done exactly 50 cycles after WAIT entry for row 2, timeout_err=1, no further begin_mult, class_out/max_value reflect rows 0-1 only.
REQ-037 rst pulsed while in WAIT for row 4 -> all outputs at reset values asynchronously, no done pulse; a new start then produces begin_mult with row_select=0.
REQ-038 start held high throughout an evaluation, plus stray done_row pulses in ISSUE/CAPTURE -> exactly NUM_ROWS begin_mult pulses and results unaffected; a new evaluation starts in the cycle after returning to IDLE.

Source files
------------

// File: rtl/row_sequencer_if.sv
// row_sequencer_if: bundles the multiplier handshake and result signals of the row sequencer
interface row_sequencer_if;
  logic        start;
  logic        done_row;
  logic [15:0] row_result;
  logic        overflow;
  logic        begin_mult;
  logic [3:0]  row_select;
  logic        busy;
  logic        done;
  logic [3:0]  class_out;
  logic [15:0] max_value;
  logic [15:0] ovf_mask;
  logic        timeout_err;
  modport master (
    output start, done_row, row_result, overflow,
    input  begin_mult, row_select, busy, done, class_out, max_value, ovf_mask, timeout_err
  );
  modport slave (
    input  start, done_row, row_result, overflow,
    output begin_mult, row_select, busy, done, class_out, max_value, ovf_mask, timeout_err
  );
endinterface

// File: rtl/row_sequencer.sv
// row_sequencer: issues each weight row to the multiplier in turn and keeps the arg-max row
module row_sequencer #(
  parameter int NUM_ROWS       = 10,
  parameter int TIMEOUT_CYCLES = 2047
) (
  input  logic           clk,
  input  logic           rst,
  row_sequencer_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_FINISH} state_t;
  localparam logic [3:0]  LAST_ROW  = 4'(NUM_ROWS - 1);
  localparam logic [15:0] CNT_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  state_t      r_state, w_next;
  logic        r_begin, r_busy, r_done, r_terr, r_ovf;
  logic [3:0]  r_row, r_class;
  logic [15:0] r_max, r_mask, r_cnt, r_res;
  logic [15:0] w_eff;
  logic        w_last, w_expire, w_better;
  assign w_last   = r_row == LAST_ROW;
  assign w_expire = r_cnt == CNT_LIMIT;
  assign w_eff    = r_ovf ? 16'hFFFF : r_res;
  assign w_better = (r_row == 4'd0) || (w_eff > r_max);
  assign bus.begin_mult  = r_begin;
  assign bus.row_select  = r_row;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.class_out   = r_class;
  assign bus.max_value   = r_max;
  assign bus.ovf_mask    = r_mask;
  assign bus.timeout_err = r_terr;
  // next state; the counter reaching its limit on the edge means TIMEOUT_CYCLES wait cycles elapsed
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = bus.start ? S_ISSUE : S_IDLE;
      S_ISSUE:   w_next = S_WAIT;
      S_WAIT:    w_next = bus.done_row ? S_CAPTURE : (w_expire ? S_FINISH : S_WAIT);
      S_CAPTURE: w_next = w_last ? S_FINISH : S_ISSUE;
      S_FINISH:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end
  // registered strobes derived from the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_begin <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_begin <= w_next == S_ISSUE;
      r_busy  <= w_next != S_IDLE;
      r_done  <= w_next == S_FINISH;
    end
  end
  // wait counter is held at zero outside WAIT, so it starts from zero on every entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else     r_cnt <= (r_state == S_WAIT) ? r_cnt + 16'd1 : '0;
  end
  // latch the multiplier answer on the edge that accepts done_row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res <= '0;
      r_ovf <= 1'b0;
    end else if (r_state == S_WAIT && bus.done_row) begin
      r_res <= bus.row_result;
      r_ovf <= bus.overflow;
    end
  end
  // row index, arg-max tracking, overflow mask and timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row   <= '0;
      r_class <= '0;
      r_max   <= '0;
      r_mask  <= '0;
      r_terr  <= 1'b0;
    end else if (r_state == S_IDLE && bus.start) begin
      r_row   <= '0;
      r_class <= '0;
      r_max   <= '0;
      r_mask  <= '0;
      r_terr  <= 1'b0;
    end else if (r_state == S_WAIT && !bus.done_row && w_expire) begin
      r_terr  <= 1'b1;
    end else if (r_state == S_CAPTURE) begin
      r_mask[r_row] <= r_ovf;
      r_class <= w_better ? r_row : r_class;
      r_max   <= w_better ? w_eff : r_max;
      r_row   <= w_last ? r_row : r_row + 4'd1;
    end
  end
endmodule

// File: tb/tb_row_sequencer.sv
// tb_row_sequencer: directed and randomized evaluations against a behavioural arg-max model
module tb_row_sequencer;
  localparam int NR = 10;
  localparam int TO = 50;
  logic clk = 1'b0;
  logic rst = 1'b1;
  row_sequencer_if bus();
  row_sequencer #(.NUM_ROWS(NR), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  int n_checks = 0;
  int n_err = 0;
  logic [15:0] cfg_res [16];
  bit          cfg_ovf [16];
  int          cfg_lat [16];
  bit          cfg_silent [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_begin"}, 32'(bus.begin_mult), 0);
    chk({tag, "_busy"},  32'(bus.busy), 0);
    chk({tag, "_done"},  32'(bus.done), 0);
    chk({tag, "_terr"},  32'(bus.timeout_err), 0);
    chk({tag, "_row"},   32'(bus.row_select), 0);
    chk({tag, "_class"}, 32'(bus.class_out), 0);
    chk({tag, "_max"},   32'(bus.max_value), 0);
    chk({tag, "_mask"},  32'(bus.ovf_mask), 0);
  endtask

  // arg-max with ties to the lower index over the rows answered before any silent row
  task automatic model(output int e_class, output int e_max, output int e_mask, output int e_terr, output int e_begins);
    int answered = NR;
    e_terr = 0;
    for (int r = 0; r < NR; r++) if (cfg_silent[r] && e_terr == 0) begin answered = r; e_terr = 1; end
    e_begins = e_terr ? answered + 1 : NR;
    e_class = 0; e_max = 0; e_mask = 0;
    for (int r = 0; r < answered; r++) begin
      int eff = cfg_ovf[r] ? 65535 : int'(cfg_res[r]);
      if (r == 0 || eff > e_max) begin e_class = r; e_max = eff; end
      if (cfg_ovf[r]) e_mask |= 1 << r;
    end
  endtask

  task automatic run_eval(input bit hold_start, input bit stray, input int abort_row);
    int cyc = 0, cd = -1, n_begin = 0, ans_row = 0, exp_begin = 1, exp_done = -1;
    int e_class, e_max, e_mask, e_terr, e_begins;
    bit got_done = 0, stray_pend = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.done_row = 1'b1;
    bus.row_result = 16'hFFFF;
    bus.overflow = 1'b1;
    for (int k = 0; k < 1000 && !got_done; k++) begin
      @(negedge clk);
      cyc++;
      if (!hold_start) bus.start = 1'b0;
      bus.done_row = 1'b0;
      bus.row_result = 16'($urandom);
      bus.overflow = 1'($urandom);
      if (stray_pend) begin
        bus.done_row = 1'b1; bus.row_result = 16'hFFFF; bus.overflow = 1'b1; stray_pend = 0;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus.done_row = 1'b1;
          bus.row_result = cfg_res[ans_row];
          bus.overflow = cfg_ovf[ans_row];
          exp_begin = cyc + 2;
          exp_done = cyc + 2;
          stray_pend = stray;
          cd = -1;
        end
      end
      if (bus.begin_mult) begin
        chk("begin_row", 32'(bus.row_select), 32'(n_begin));
        chk("begin_cycle", 32'(cyc), 32'(exp_begin));
        ans_row = int'(bus.row_select);
        n_begin++;
        if (n_begin - 1 == abort_row) return;
        cd = cfg_silent[ans_row] ? -1 : cfg_lat[ans_row];
        if (cfg_silent[ans_row]) exp_done = cyc + 1 + TO;
        if (stray) begin bus.done_row = 1'b1; bus.row_result = 16'hFFFF; bus.overflow = 1'b1; end
      end
      if (bus.done) begin
        got_done = 1;
        chk("done_cycle", 32'(cyc), 32'(exp_done));
        chk("finish_busy", 32'(bus.busy), 1);
      end
    end
    if (!got_done) begin
      chk("done_budget", 0, 1);
      return;
    end
    bus.done_row = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", 32'(bus.done), 0);
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_begin", 32'(bus.begin_mult), 0);
    model(e_class, e_max, e_mask, e_terr, e_begins);
    chk("n_begin", 32'(n_begin), 32'(e_begins));
    chk("class_out", 32'(bus.class_out), 32'(e_class));
    chk("max_value", 32'(bus.max_value), 32'(e_max));
    chk("ovf_mask", 32'(bus.ovf_mask), 32'(e_mask));
    chk("timeout_err", 32'(bus.timeout_err), 32'(e_terr));
  endtask

  task automatic cfg_fill(input int res_mode, input int lat);
    for (int r = 0; r < 16; r++) begin
      cfg_res[r] = res_mode == 0 ? 16'(100 * (r + 1)) : res_mode == 1 ? 16'd784 :
                   res_mode == 2 ? 16'd500 : res_mode == 3 ? 16'($urandom_range(0, 3) * 1000) : 16'($urandom);
      cfg_ovf[r] = 1'b0;
      cfg_lat[r] = lat > 0 ? lat : int'($urandom_range(1, 8));
      cfg_silent[r] = 1'b0;
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.done_row = 1'b0; bus.row_result = '0; bus.overflow = 1'b0;
    #1 chk_reset_vals("por");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("after_rst");
    cfg_fill(0, 5);
    run_eval(0, 0, -1);
    cfg_fill(1, 0);
    run_eval(0, 0, -1);
    cfg_fill(2, 0);
    cfg_ovf[3] = 1'b1;
    run_eval(0, 0, -1);
    cfg_fill(4, 0);
    cfg_silent[2] = 1'b1;
    run_eval(0, 0, -1);
    for (int t = 0; t < 6; t++) begin
      cfg_fill(t % 2 ? 3 : 4, 0);
      for (int r = 0; r < NR; r++) cfg_ovf[r] = $urandom_range(0, 9) == 0;
      if (t == 5) cfg_silent[$urandom_range(0, NR - 1)] = 1'b1;
      run_eval(0, 0, -1);
    end
    cfg_fill(3, 0);
    cfg_ovf[$urandom_range(0, NR - 1)] = 1'b1;
    run_eval(1, 1, -1);
    @(negedge clk);
    chk("restart_begin", 32'(bus.begin_mult), 1);
    chk("restart_row", 32'(bus.row_select), 0);
    bus.start = 1'b0;
    #2 rst = 1'b1;
    #1 chk_reset_vals("restart_abort");
    @(negedge clk);
    rst = 1'b0;
    cfg_fill(0, 6);
    cfg_ovf[1] = 1'b1;
    run_eval(0, 0, 4);
    @(negedge clk);
    @(negedge clk);
    chk("wait_busy", 32'(bus.busy), 1);
    #2 rst = 1'b1;
    #1 chk_reset_vals("async_rst");
    @(negedge clk);
    chk_reset_vals("rst_held");
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("no_done_after_abort", 32'(bus.done), 0);
    end
    cfg_fill(4, 0);
    run_eval(0, 0, -1);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
